image_sprite_writer: RTL and testbench

IMAGE_SPRITE_WRITER -- requirements
Module: image_sprite_writer

---
 rtl/image_sprite_writer.sv | 100 ++++++++++
 tb/tb_image_sprite_writer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/image_sprite_writer.sv
// rtl/image_sprite_writer.sv - streams row-major palette pixels into an image BRAM, one write per accepted pixel
module image_sprite_writer #(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256,
    localparam int AW    = (WIDTH * HEIGHT > 1) ? $clog2(WIDTH * HEIGHT) : 1
) (
    input  logic          pixel_clk_in,
    input  logic          rst_in,
    input  logic          start_in,
    input  logic          abort_in,
    input  logic [7:0]    data_in,
    input  logic          valid_in,
    output logic          ready_out,
    output logic [AW-1:0] addr_out,
    output logic [7:0]    wdata_out,
    output logic          we_out,
    output logic          busy_out,
    output logic          done_out
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [AW-1:0] pix_addr_q;
    logic          accept;
    logic          last_accept;
    logic          start_load;

    assign ready_out   = (state_q == LOAD);
    assign busy_out    = (state_q == LOAD);
    assign accept      = valid_in && (state_q == LOAD) && !abort_in;
    assign last_accept = accept && (x_q == X_LAST) && (y_q == Y_LAST);
    assign start_load  = (state_q == IDLE) && start_in;

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_in) state_d = LOAD;
            LOAD: if (abort_in || last_accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // pix_addr_q tracks y*WIDTH+x incrementally so no multiplier is needed
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            x_q        <= '0;
            y_q        <= '0;
            pix_addr_q <= '0;
        end else if (start_load) begin
            x_q        <= '0;
            y_q        <= '0;
            pix_addr_q <= '0;
        end else if (accept) begin
            pix_addr_q <= pix_addr_q + AW'(1);
            if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= y_q + YW'(1);
            end else begin
                x_q <= x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            addr_out  <= '0;
            wdata_out <= '0;
            we_out    <= 1'b0;
            done_out  <= 1'b0;
        end else begin
            we_out   <= accept;
            done_out <= last_accept;
            if (accept) begin
                addr_out  <= pix_addr_q;
                wdata_out <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_image_sprite_writer.sv
// tb/tb_image_sprite_writer.sv - randomized and directed bench against a pixel-count reference model
module tb_image_sprite_writer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int NP = W * H;
    localparam int AW = $clog2(NP);

    logic          pixel_clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          start_in = 1'b0;
    logic          abort_in = 1'b0;
    logic [7:0]    data_in = '0;
    logic          valid_in = 1'b0;
    logic          ready_out;
    logic [AW-1:0] addr_out;
    logic [7:0]    wdata_out;
    logic          we_out;
    logic          busy_out;
    logic          done_out;

    int checks = 0;
    int failures = 0;

    // reference model: a loading flag and the number of pixels taken so far
    bit       m_loading = 0;
    int       m_count = 0;
    bit       m_we = 0;
    bit       m_done = 0;
    int       m_addr = 0;
    int       m_data = 0;
    int       wr_cnt = 0;
    int       done_cnt = 0;

    image_sprite_writer #(.WIDTH(W), .HEIGHT(H)) dut (
        .pixel_clk_in(pixel_clk_in),
        .rst_in(rst_in),
        .start_in(start_in),
        .abort_in(abort_in),
        .data_in(data_in),
        .valid_in(valid_in),
        .ready_out(ready_out),
        .addr_out(addr_out),
        .wdata_out(wdata_out),
        .we_out(we_out),
        .busy_out(busy_out),
        .done_out(done_out)
    );

    always #5 pixel_clk_in = ~pixel_clk_in;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_we"}, int'(we_out), int'(m_we));
        check({pfx, "_addr"}, int'(addr_out), m_addr);
        check({pfx, "_wdata"}, int'(wdata_out), m_data);
        check({pfx, "_done"}, int'(done_out), int'(m_done));
        check({pfx, "_busy"}, int'(busy_out), int'(m_loading));
        check({pfx, "_ready"}, int'(ready_out), int'(m_loading));
    endtask

    // advance one clock with the inputs currently driven, then compare
    task automatic step();
        m_we = 0;
        m_done = 0;
        if (m_loading && valid_in && !abort_in) begin
            m_we = 1;
            m_addr = m_count;
            m_data = int'(data_in);
            m_count++;
            if (m_count == NP) begin
                m_loading = 0;
                m_done = 1;
            end
        end else if (m_loading && abort_in) begin
            m_loading = 0;
        end else if (!m_loading && start_in) begin
            m_loading = 1;
            m_count = 0;
        end
        @(posedge pixel_clk_in);
        #1;
        if (we_out) wr_cnt++;
        if (done_out) done_cnt++;
        check_outputs("cyc");
    endtask

    task automatic drive(input bit s, input bit a, input bit v, input logic [7:0] d);
        start_in = s;
        abort_in = a;
        valid_in = v;
        data_in  = d;
        step();
    endtask

    task automatic async_reset();
        #2;
        rst_in = 1'b0;
        #1;
        m_loading = 0;
        m_we = 0;
        m_done = 0;
        m_addr = 0;
        m_data = 0;
        m_count = 0;
        check_outputs("rst");
        start_in = 0;
        abort_in = 0;
        valid_in = 0;
        @(posedge pixel_clk_in);
        #1;
        check_outputs("rst_hold");
        rst_in = 1'b1;
    endtask

    initial begin
        rst_in = 1'b0;
        repeat (2) @(posedge pixel_clk_in);
        #1;
        check_outputs("por");
        rst_in = 1'b1;

        // full load followed immediately by a start in the done cycle
        drive(1, 0, 0, 8'h00);
        wr_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < NP; i++) begin
            drive(0, 0, 1, 8'h10 + 8'(i));
            if (i == 4) check("row_wrap_addr", int'(addr_out), 4);
        end
        check("full_done_addr", int'(addr_out), NP - 1);
        check("full_done_pulse", int'(done_out), 1);
        check("full_writes", wr_cnt, NP);
        drive(1, 0, 0, 8'h00);
        check("done_one_cycle", int'(done_out), 0);
        check("restart_busy", int'(busy_out), 1);
        drive(0, 0, 1, 8'h55);
        check("restart_addr0", int'(addr_out), 0);
        for (int i = 1; i < NP; i++) drive(0, 0, 1, 8'(i));
        check("second_done", done_cnt, 2);
        drive(0, 0, 0, 8'h00);
        check("idle_busy_low", int'(busy_out), 0);

        // stalls every other cycle
        drive(1, 0, 0, 8'h00);
        wr_cnt = 0;
        for (int i = 0; i < 2 * NP; i++) drive(0, 0, (i % 2) == 0, 8'h20 + 8'(i));
        check("stall_writes", wr_cnt, NP);

        // abort after three pixels, pixel presented on the abort cycle
        drive(1, 0, 0, 8'h00);
        wr_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 8'h30 + 8'(i));
        drive(0, 1, 1, 8'hAA);
        check("abort_ready", int'(ready_out), 0);
        drive(0, 1, 1, 8'hBB);
        check("abort_writes", wr_cnt, 3);
        check("abort_no_done", done_cnt, 0);
        drive(1, 1, 0, 8'h00);
        drive(0, 0, 1, 8'h40);
        check("abort_restart_addr", int'(addr_out), 0);
        for (int i = 1; i < NP; i++) drive(0, 0, 1, 8'h40 + 8'(i));

        // reset after five pixels, then restart with starts issued mid-load
        drive(1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 8'h50 + 8'(i));
        done_cnt = 0;
        async_reset();
        wr_cnt = 0;
        drive(0, 0, 1, 8'h60);
        drive(0, 0, 1, 8'h61);
        check("no_start_no_write", wr_cnt, 0);
        check("rst_no_done", done_cnt, 0);
        drive(1, 0, 0, 8'h00);
        for (int i = 0; i < NP; i++) drive(i == 2, 0, 1, 8'h70 + 8'(i));
        check("start_ignored_writes", wr_cnt, NP);
        check("start_ignored_done", done_cnt, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 2) != 0, 8'($urandom));
            if ($urandom_range(0, 999) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
